// File: rtl/rotor.sv
// Loadable one-position rotate register: each rising edge either resets, parallel-loads,
// rotates right or left by one bit, or holds. The output is the register itself.
module rotor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sigright,
  input  logic             sigleft,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [2:0] {
    OpHold,
    OpClear,
    OpLoad,
    OpRotR,
    OpRotL
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] rot_left;

  // Priority decode; both rotate enables together is a defined no-op.
  always_comb begin
    op = OpHold;
    if (rst) begin
      op = OpClear;
    end else if (load) begin
      op = OpLoad;
    end else if (sigright && !sigleft) begin
      op = OpRotR;
    end else if (sigleft && !sigright) begin
      op = OpRotL;
    end
  end

  assign rot_right = {r_q[0], r_q[WIDTH-1:1]};
  assign rot_left  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};

  always_comb begin
    r_d = r_q;
    unique case (op)
      OpClear: r_d = '0;
      OpLoad:  r_d = in;
      OpRotR:  r_d = rot_right;
      OpRotL:  r_d = rot_left;
      default: r_d = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    r_q <= r_d;
  end

  assign out = r_q;

endmodule

// File: tb/tb_rotor.sv
// Directed self-checking bench for rotor: reset priority, load, rotations, conflict,
// full wrap and reset in the middle of a rotation sequence.
module tb_rotor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic         sigright;
  logic         sigleft;
  logic [W-1:0] in;
  logic [W-1:0] out;

  int checks = 0;
  int errors = 0;

  rotor #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .sigright (sigright),
    .sigleft  (sigleft),
    .in       (in),
    .out      (out)
  );

  always #5 clk = ~clk;

  // Apply controls away from the edge, take one rising edge, then sample.
  task automatic step(input logic r, input logic ld, input logic sr, input logic sl,
                      input logic [W-1:0] d);
    @(negedge clk);
    rst      = r;
    load     = ld;
    sigright = sr;
    sigleft  = sl;
    in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (out === exp) else begin
      errors++;
      $error("FAIL %s: out=%h expected=%h", tag, out, exp);
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; sigright = 1'b0; sigleft = 1'b0; in = '0;

    // Reset overrides a simultaneous load
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF); check("reset_over_load", 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF); check("load_ff", 8'hFF);

    // Load then rotate right three times
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hB3); check("load_b3", 8'hB3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); check("rotr_1", 8'hD9);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); check("rotr_2", 8'hEC);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); check("rotr_3", 8'h76);

    // Rotate left back to the original
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("rotl_1", 8'hEC);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("rotl_2", 8'hD9);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("rotl_3", 8'hB3);

    // Load beats rotate; both rotates together hold; idle holds
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A); check("load_over_rotr", 8'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C); check("load_over_rotl", 8'h3C);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A); check("load_5a", 8'h5A);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF); check("conflict_1", 8'h5A);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF); check("conflict_2", 8'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF); check("idle_hold", 8'h5A);

    // Full wrap: eight left rotations of 8'h81
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h81); check("load_81", 8'h81);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_1", 8'h03);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_2", 8'h06);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_3", 8'h0C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_4", 8'h18);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_5", 8'h30);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_6", 8'h60);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_7", 8'hC0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check("wrap_8", 8'h81);

    // Right rotation of 8'h81 wraps the LSB into the MSB
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); check("rotr_81", 8'hC0);

    // Reset mid-rotation; zero stays zero while rotating
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hB3); check("load_b3_again", 8'hB3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); check("mid_rotr", 8'hD9);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); check("mid_reset", 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); check("zero_rotr_1", 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); check("zero_rotr_2", 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C); check("reload_3c", 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
